// File: rtl/uart_rx_8n1_if.sv
// Receive-side output bundle for uart_rx_8n1: byte holding register handshake,
// error pulses and busy indication.
interface uart_rx_8n1_if;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    modport master (
        output data_o,
        output valid_o,
        output frame_err_o,
        output overrun_o,
        output busy_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  valid_o,
        input  frame_err_o,
        input  overrun_o,
        input  busy_o,
        output ready_i
    );
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling FSM and a
// one-entry valid/ready holding register with framing-error and overrun pulses.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 868,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          rx_i,
    uart_rx_8n1_if.master rx_if
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          busy_q, busy_d;
    logic          sync1_q, sync2_q;
    logic          rx_s;
    logic          complete_s;

    assign rx_s = sync2_q;

    // Two-flop synchroniser for the asynchronous serial line (idle high).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    // State, counters and output holding registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, bit sampling and holding-register handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        idx_d      = idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        complete_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        complete_s = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_BREAK: begin
                // Line held low after a bad stop bit: wait quietly for idle.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // A same-cycle consume frees the register for the completing byte.
        if (complete_s) begin
            if (!valid_q || rx_if.ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_if.ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    assign busy_d = (state_d != S_IDLE);

    assign rx_if.data_o      = data_q;
    assign rx_if.valid_o     = valid_q;
    assign rx_if.frame_err_o = ferr_q;
    assign rx_if.overrun_o   = ovr_q;
    assign rx_if.busy_o      = busy_q;

endmodule
